// File: rtl/pwm_ramp.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp
// Purpose  : Slew-rate limiter placed directly ahead of the PWM generator.
//            Accepts a target duty over a valid/ready handshake and moves
//            duty_o toward it by STEP every TICK_DIV clocks. The motors
//            therefore never see a step change in speed. All values are
//            clamped to the live PWM period (max_i), and an emergency stop
//            input is provided.
//
// Ports    : clk        - system clock
//            rst        - synchronous active-high reset
//            max_i      - PWM period in cycles (upper clamp for duty/target)
//            tgt_i      - requested duty in cycles
//            tgt_valid  - tgt_i is valid
//            tgt_ready  - block can accept a target (low while estop)
//            estop      - emergency stop, level-sensitive
//            duty_o     - ramped duty, feeds the generator's pwm_i
//            busy       - ramp in progress (state is not IDLE)
//            at_target  - duty_o equals the registered target
//
// Options  : SOFT_STOP_EN - when defined, estop ramps duty down to 0 at
//            4*STEP per tick instead of forcing it to 0 at once.
//
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp #(
    parameter int DW       = 16,
    parameter int TICK_DIV = 500,
    parameter int STEP     = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] max_i,
    input  logic [DW-1:0] tgt_i,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    input  logic          estop,
    output logic [DW-1:0] duty_o,
    output logic          busy,
    output logic          at_target
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam int            CW             = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_TICK_LAST    = CW'(TICK_DIV - 1);
    localparam logic [DW:0]   C_STEP_EXT     = (DW+1)'(STEP);
    localparam logic [DW-1:0] C_STEP         = DW'(STEP);
`ifdef SOFT_STOP_EN
    localparam logic [DW:0]   C_STOP_STEP_EXT = (DW+1)'(4 * STEP);
    localparam logic [DW-1:0] C_STOP_STEP     = DW'(4 * STEP);
`endif

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_duty, w_duty_nxt;
    logic [DW-1:0] r_target, w_target_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic          w_tick;
    logic          w_xfer;
    logic          w_clamp;
    logic [DW-1:0] w_tgt_in;
    logic [DW:0]   w_gap_up;
    logic [DW:0]   w_gap_dn;

    // ------------------------------------------------------------------------
    // Handshake, tick and distance helpers
    // ------------------------------------------------------------------------
    assign tgt_ready = ~estop;
    assign w_xfer    = tgt_valid & tgt_ready;
    assign w_tick    = (r_cnt == C_TICK_LAST);
    assign w_tgt_in  = (tgt_i < max_i) ? tgt_i : max_i;
    // Any pending period clamp blocks a ramp step in the same cycle. This
    // keeps a step from landing above a freshly reduced period.
    assign w_clamp   = (r_target > max_i) | (r_duty > max_i);
    // Extended by one bit so that a wrong-direction subtract cannot alias
    // into a small positive gap.
    assign w_gap_up  = {1'b0, r_target} - {1'b0, r_duty};
    assign w_gap_dn  = {1'b0, r_duty} - {1'b0, r_target};

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_duty   <= '0;
            r_target <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_duty   <= w_duty_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // Priority: estop > period clamp > transfer > ramp step
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_duty_nxt   = r_duty;
        w_target_nxt = r_target;
        w_cnt_nxt    = w_tick ? '0 : r_cnt + 1'b1;

        if (w_xfer) begin
            w_cnt_nxt = '0;
        end

        if (estop) begin
`ifdef SOFT_STOP_EN
            w_target_nxt = '0;
            w_state_nxt  = ST_DOWN;
            if (w_tick) begin
                w_duty_nxt = ({1'b0, r_duty} <= C_STOP_STEP_EXT) ? '0
                                                                  : r_duty - C_STOP_STEP;
            end
`else
            w_duty_nxt   = '0;
            w_target_nxt = '0;
            w_state_nxt  = ST_IDLE;
`endif
        end else begin
            if (r_target > max_i) begin
                w_target_nxt = max_i;
            end else if (w_xfer) begin
                w_target_nxt = w_tgt_in;
            end

            if (r_duty > max_i) begin
                w_duty_nxt = max_i;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_target > r_duty) begin
                        w_state_nxt = ST_UP;
                    end else if (r_target < r_duty) begin
                        w_state_nxt = ST_DOWN;
                    end
                end
                default: begin
                    // Direction follows the registered target every cycle,
                    // so a crossing retarget flips UP/DOWN directly.
                    if (r_target == r_duty) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_target > r_duty) begin
                        w_state_nxt = ST_UP;
                        if (w_tick && !w_clamp) begin
                            if (w_gap_up <= C_STEP_EXT) begin
                                w_duty_nxt  = r_target;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_duty_nxt = r_duty + C_STEP;
                            end
                        end
                    end else begin
                        w_state_nxt = ST_DOWN;
                        if (w_tick && !w_clamp) begin
                            if (w_gap_dn <= C_STEP_EXT) begin
                                w_duty_nxt  = r_target;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_duty_nxt = r_duty - C_STEP;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign duty_o    = r_duty;
    assign busy      = (r_state != ST_IDLE);
    assign at_target = (r_duty == r_target);

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp
// Purpose  : Directed self-checking bench for pwm_ramp with TICK_DIV=4,
//            STEP=100 and max_i=50000. Inputs change 1 time unit after a
//            rising edge, and outputs are sampled at that same point.
//            A sample therefore shows the result of the edge just passed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp;

    localparam int DW       = 16;
    localparam int TICK_DIV = 4;
    localparam int STEP     = 100;

    logic          clk;
    logic          rst;
    logic [DW-1:0] max_i;
    logic [DW-1:0] tgt_i;
    logic          tgt_valid;
    logic          tgt_ready;
    logic          estop;
    logic [DW-1:0] duty_o;
    logic          busy;
    logic          at_target;

    int n_total;
    int n_bad;

    pwm_ramp #(
        .DW       (DW),
        .TICK_DIV (TICK_DIV),
        .STEP     (STEP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .max_i     (max_i),
        .tgt_i     (tgt_i),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .estop     (estop),
        .duty_o    (duty_o),
        .busy      (busy),
        .at_target (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one target for a single edge. On return, the accepting edge has
    // just occurred.
    task automatic send(input logic [DW-1:0] v);
        tgt_i     = v;
        tgt_valid = 1'b1;
        step(1);
        tgt_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        max_i     = 16'd50000;
        tgt_i     = '0;
        tgt_valid = 1'b0;
        estop     = 1'b0;
        step(2);
        rst = 1'b0;

        // ---- reset state ----
        check("rst_duty",  duty_o,    0);
        check("rst_ready", tgt_ready, 1);
        check("rst_busy",  busy,      0);
        check("rst_at",    at_target, 1);

        // ---- 1: ramp 0 -> 20000 ----
        send(16'd20000);
        step(3);
        check("s1_e3_duty", duty_o, 0);
        check("s1_e3_busy", busy,   1);
        step(1);
        check("s1_e4_duty", duty_o, 100);
        step(4);
        check("s1_e8_duty", duty_o, 200);
        step(791);
        check("s1_e799_duty", duty_o, 19900);
        step(1);
        check("s1_e800_duty", duty_o, 20000);
        check("s1_e800_busy", busy,   0);
        check("s1_e800_at",   at_target, 1);

        // ---- 2: partial last step ----
        do_reset();
        send(16'd250);
        step(4);
        check("s2_t1", duty_o, 100);
        step(4);
        check("s2_t2", duty_o, 200);
        step(4);
        check("s2_t3", duty_o, 250);
        check("s2_busy", busy, 0);
        check("s2_at",   at_target, 1);

        // ---- 3: crossing retarget mid-ramp ----
        do_reset();
        send(16'd2000);
        step(40);
        check("s3_pre", duty_o, 1000);
        send(16'd500);
        check("s3_hold", duty_o, 1000);
        for (int k = 1; k <= 5; k++) begin
            step(2);
            check("s3_mid_busy", busy, 1);
            step(2);
            check("s3_duty", duty_o, 1000 - 100 * k);
            check("s3_busy", busy, (k < 5) ? 1 : 0);
        end

        // ---- 4: target clamp, then period drop ----
        do_reset();
        send(16'd60000);
        step(2000);
        check("s4_tclamp_duty", duty_o, 50000);
        check("s4_tclamp_busy", busy, 0);
        step(8);
        check("s4_tclamp_hold", duty_o, 50000);
        do_reset();
        send(16'd50000);
        step(1600);
        check("s4_pre", duty_o, 40000);
        max_i = 16'd30000;
        step(1);
        check("s4_dclamp", duty_o, 30000);
        step(1);
        check("s4_idle_busy", busy, 0);
        check("s4_idle_at",   at_target, 1);
        max_i = 16'd50000;

        // ---- 5: emergency stop at 5000, with a blocked request ----
        do_reset();
        send(16'd10000);
        step(200);
        check("s5_pre", duty_o, 5000);
        estop     = 1'b1;
        tgt_i     = 16'd8000;
        tgt_valid = 1'b1;
        #1;
        check("s5_ready_low", tgt_ready, 0);
`ifdef SOFT_STOP_EN
        step(1);
        check("s5_soft_e1", duty_o, 5000);
        step(3);
        check("s5_soft_t1", duty_o, 4600);
        step(4);
        check("s5_soft_t2", duty_o, 4200);
        step(44);
        check("s5_soft_zero", duty_o, 0);
        step(4);
        check("s5_soft_hold", duty_o, 0);
`else
        step(1);
        check("s5_hard_duty", duty_o, 0);
        check("s5_hard_busy", busy, 0);
        step(3);
        check("s5_hard_hold", duty_o, 0);
        check("s5_hard_ready", tgt_ready, 0);
`endif
        estop     = 1'b0;
        tgt_valid = 1'b0;
        step(1);
        check("s5_rel_ready", tgt_ready, 1);
        check("s5_rel_duty",  duty_o, 0);
        check("s5_rel_busy",  busy, 0);
        check("s5_rel_at",    at_target, 1);
        step(8);
        check("s5_rel_hold",  duty_o, 0);

        // ---- 6: reset mid-ramp ----
        do_reset();
        send(16'd10000);
        step(120);
        check("s6_pre", duty_o, 3000);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("s6_duty",  duty_o, 0);
        check("s6_busy",  busy, 0);
        check("s6_at",    at_target, 1);
        check("s6_ready", tgt_ready, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
